// File: rtl/button_event_encoder.sv
// Button event encoder: turns debounced levels from four buttons into
// single-button press events that are reported on release and held until
// acknowledged. Chords raise multi_err_o; with STUCK_TIMEOUT_EN defined, a
// button held for HOLD_LIMIT cycles raises stuck_err_o and produces no event.
// Optional feature macro: STUCK_TIMEOUT_EN (undefined = no hold timeout).
module button_event_encoder #(
  parameter int unsigned HOLD_LIMIT = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] bp_i,
  input  logic       press_ack_i,
  output logic       press_valid_o,
  output logic [1:0] press_idx_o,
  output logic       multi_err_o,
  output logic       stuck_err_o,
  output logic [7:0] press_count_o
);

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StReport,
    StWaitRel
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       multi_q, multi_d;
  logic       stuck_q, stuck_d;
  logic [7:0] count_q, count_d;

  logic       hold_expired;
  logic [3:0] held_mask;

  // Button numbering is reversed against bit order: bp[3] is button 0.
  function automatic logic [1:0] btn_num(input logic [3:0] oh);
    logic [1:0] num;
    case (oh)
      4'b1000: num = 2'd0;
      4'b0100: num = 2'd1;
      4'b0010: num = 2'd2;
      default: num = 2'd3;
    endcase
    return num;
  endfunction

  assign held_mask = 4'b1000 >> idx_q;

`ifdef STUCK_TIMEOUT_EN
  localparam int unsigned CntW = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT) : 1;

  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

  // Cleared while idle so it starts at zero on every entry to HELD.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == StIdle) begin
      hold_cnt_d = '0;
    end else if (state_q == StHeld) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Expires on the HOLD_LIMIT-th edge spent holding the same button.
  assign hold_expired = (hold_cnt_q == CntW'(HOLD_LIMIT - 1));
`else
  logic unused_hold_limit;
  assign unused_hold_limit = ^HOLD_LIMIT;
  assign hold_expired      = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    multi_d = 1'b0;
    stuck_d = 1'b0;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if ($onehot(bp_i)) begin
          state_d = StHeld;
          idx_d   = btn_num(bp_i);
        end else if (bp_i != 4'b0000) begin
          state_d = StWaitRel;
          multi_d = 1'b1;
        end
      end
      StHeld: begin
        if (bp_i == held_mask) begin
          if (hold_expired) begin
            state_d = StWaitRel;
            stuck_d = 1'b1;
          end
        end else if (bp_i == 4'b0000) begin
          state_d = StReport;
          valid_d = 1'b1;
        end else begin
          state_d = StWaitRel;
          multi_d = 1'b1;
        end
      end
      StReport: begin
        // Buttons are ignored here; only the ack matters.
        if (press_ack_i) begin
          valid_d = 1'b0;
          count_d = count_q + 8'd1;
          state_d = (bp_i == 4'b0000) ? StIdle : StWaitRel;
        end
      end
      StWaitRel: begin
        if (bp_i == 4'b0000) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      stuck_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      stuck_q <= stuck_d;
      count_q <= count_d;
    end
  end

  assign press_valid_o = valid_q;
  assign press_idx_o   = idx_q;
  assign multi_err_o   = multi_q;
  assign stuck_err_o   = stuck_q;
  assign press_count_o = count_q;

endmodule
